sp_instr_sequencer: RTL and testbench

//   Pops scratchpad instructions (instrFIFO_t) and expands each into row requests: LOAD -> 4 DRAM row-load requests,

---
 rtl/sp_instr_sequencer_if.sv | 65 ++++++
 rtl/sp_instr_sequencer.sv | 136 +++++++++++++
 tb/tb_sp_instr_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sp_instr_sequencer_if.sv
// Shared types and the handshake bundle between the instruction FIFO, scratchpad
// read FIFO, DRAM load path and GEMM dispatch port of the scratchpad sequencer.
package sp_instr_sequencer_pkg;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned MAT_S_W = 4;
    localparam int unsigned ROW_S_W = 2;
    localparam int unsigned ROWS    = 1 << ROW_S_W;
    localparam int unsigned STRIDE  = 8;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned MAT_T_W = 2;
    localparam int unsigned FIELD_W = MAT_S_W + 2;

    typedef enum logic [OP_W-1:0] {
        OP_ILLEGAL = 2'b00,
        OP_LOAD    = 2'b01,
        OP_STORE   = 2'b10,
        OP_GEMM    = 2'b11
    } opcode_e;

    typedef struct packed {
        logic [OP_W-1:0]    opcode;
        logic [FIELD_W-1:0] ls_matrix_rd_gemm_new_weight;
        logic [WORD_W-1:0]  ls_addr_gemm_gemm_sel;
    } instr_fifo_t;

    typedef struct packed {
        logic [WORD_W-1:0]  addr;
        logic [MAT_T_W-1:0] mat_t;
        logic [MAT_S_W-1:0] mat_s;
        logic [ROW_S_W-1:0] row_s;
    } r_fifo_t;
endpackage

interface sp_instr_sequencer_if;
    import sp_instr_sequencer_pkg::*;

    logic                instr_valid;
    instr_fifo_t         instr;
    logic                instr_ready;
    logic                rd_valid;
    r_fifo_t             rd_req;
    logic                rd_ready;
    logic                ld_valid;
    logic [WORD_W-1:0]   ld_addr;
    logic [MAT_S_W-1:0]  ld_mat_s;
    logic [ROW_S_W-1:0]  ld_row_s;
    logic                ld_ready;
    logic                gemm_valid;
    logic [MAT_S_W-1:0]  gemm_rd;
    logic                gemm_ready;
    logic                busy;
    logic                illegal_op;

    modport master (
        input  instr_valid, instr, rd_ready, ld_ready, gemm_ready,
        output instr_ready, rd_valid, rd_req, ld_valid, ld_addr, ld_mat_s, ld_row_s,
               gemm_valid, gemm_rd, busy, illegal_op
    );

    modport slave (
        output instr_valid, instr, rd_ready, ld_ready, gemm_ready,
        input  instr_ready, rd_valid, rd_req, ld_valid, ld_addr, ld_mat_s, ld_row_s,
               gemm_valid, gemm_rd, busy, illegal_op
    );
endinterface

// File: rtl/sp_instr_sequencer.sv
// Expands one scratchpad instruction at a time into row-level DRAM loads,
// scratchpad reads and a final GEMM dispatch.
module sp_instr_sequencer
    import sp_instr_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    sp_instr_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STORE, S_G_WGT, S_G_IN, S_G_PSUM, S_G_DISP
    } state_e;

    state_e              state_q, state_d;
    logic [ROW_S_W-1:0]  row_q;
    logic [MAT_S_W-1:0]  mat_q;
    logic [WORD_W-1:0]   base_q;
    logic                illegal_q;

    logic                instr_ready_c;
    logic                rd_valid_c;
    r_fifo_t             rd_req_c;
    logic                ld_valid_c;
    logic                gemm_valid_c;
    logic                instr_fire;
    logic                row_acc;
    logic                row_last;
    logic                new_weight;
    opcode_e             opcode;
    logic [WORD_W-1:0]   row_addr;
    logic                unused_field_bit;

    assign opcode           = opcode_e'(bus.instr.opcode);
    assign new_weight       = bus.instr.ls_matrix_rd_gemm_new_weight[MAT_S_W+1];
    assign unused_field_bit = bus.instr.ls_matrix_rd_gemm_new_weight[MAT_S_W];
    assign instr_fire       = bus.instr_valid & instr_ready_c;
    assign row_acc          = (rd_valid_c & bus.rd_ready) | (ld_valid_c & bus.ld_ready);
    assign row_last         = (row_q == ROW_S_W'(ROWS - 1));
    assign row_addr         = base_q + WORD_W'(row_q) * WORD_W'(STRIDE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Latched instruction fields, row counter and illegal-opcode pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q     <= '0;
            mat_q     <= '0;
            base_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= instr_fire && (opcode == OP_ILLEGAL);
            if (instr_fire) begin
                row_q  <= '0;
                mat_q  <= bus.instr.ls_matrix_rd_gemm_new_weight[MAT_S_W-1:0];
                base_q <= bus.instr.ls_addr_gemm_gemm_sel;
            end else if (row_acc) begin
                row_q  <= row_q + ROW_S_W'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (instr_fire) begin
                    unique case (opcode)
                        OP_LOAD:  state_d = S_LOAD;
                        OP_STORE: state_d = S_STORE;
                        OP_GEMM:  state_d = new_weight ? S_G_WGT : S_G_IN;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_LOAD, S_STORE: if (row_acc && row_last) state_d = S_IDLE;
            S_G_WGT:         if (row_acc && row_last) state_d = S_G_IN;
            S_G_IN:          if (row_acc && row_last) state_d = S_G_PSUM;
            S_G_PSUM:        if (row_acc && row_last) state_d = S_G_DISP;
            S_G_DISP:        if (bus.gemm_ready)      state_d = S_IDLE;
            default:         state_d = S_IDLE;
        endcase
    end

    // Output decode: depends only on state and registered fields
    always_comb begin
        instr_ready_c = 1'b0;
        rd_valid_c    = 1'b0;
        ld_valid_c    = 1'b0;
        gemm_valid_c  = 1'b0;
        rd_req_c      = '{addr: '0, mat_t: 2'b00, mat_s: '0, row_s: row_q};
        unique case (state_q)
            S_IDLE:  instr_ready_c = 1'b1;
            S_LOAD:  ld_valid_c    = 1'b1;
            S_STORE: begin
                rd_valid_c = 1'b1;
                rd_req_c   = '{addr: row_addr, mat_t: 2'b00, mat_s: mat_q, row_s: row_q};
            end
            S_G_WGT: begin
                rd_valid_c     = 1'b1;
                rd_req_c.mat_t = 2'b01;
                rd_req_c.mat_s = base_q[11:8];
            end
            S_G_IN: begin
                rd_valid_c     = 1'b1;
                rd_req_c.mat_t = 2'b10;
                rd_req_c.mat_s = base_q[15:12];
            end
            S_G_PSUM: begin
                rd_valid_c     = 1'b1;
                rd_req_c.mat_t = 2'b11;
                rd_req_c.mat_s = base_q[7:4];
            end
            S_G_DISP: gemm_valid_c = 1'b1;
            default:  instr_ready_c = 1'b0;
        endcase
    end

    assign bus.instr_ready = instr_ready_c;
    assign bus.rd_valid    = rd_valid_c;
    assign bus.rd_req      = rd_req_c;
    assign bus.ld_valid    = ld_valid_c;
    assign bus.ld_addr     = row_addr;
    assign bus.ld_mat_s    = mat_q;
    assign bus.ld_row_s    = row_q;
    assign bus.gemm_valid  = gemm_valid_c;
    assign bus.gemm_rd     = base_q[3:0];
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.illegal_op  = illegal_q;

endmodule

// File: tb/tb_sp_instr_sequencer.sv
// Directed bench for sp_instr_sequencer: LOAD/STORE/GEMM expansion, back-pressure,
// address wrap, mid-instruction reset and illegal opcode.
module tb_sp_instr_sequencer;
    import sp_instr_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    sp_instr_sequencer_if bus();

    sp_instr_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic r_fifo_t mk_rd(input logic [31:0] a, input logic [1:0] t,
                                      input logic [3:0] m, input logic [1:0] r);
        r_fifo_t x;
        x.addr = a; x.mat_t = t; x.mat_s = m; x.row_s = r;
        return x;
    endfunction

    // Present one instruction for one cycle; returns at the negedge after the pop.
    task automatic push(input logic [1:0] op, input logic [5:0] fld, input logic [31:0] a);
        @(negedge clk);
        chk("push_ready", 64'(bus.instr_ready), 64'd1);
        bus.instr_valid = 1'b1;
        bus.instr.opcode = op;
        bus.instr.ls_matrix_rd_gemm_new_weight = fld;
        bus.instr.ls_addr_gemm_gemm_sel = a;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr = '0;
    endtask

    task automatic exp_rd(input string tag, input r_fifo_t e);
        chk({tag, "_v"}, 64'(bus.rd_valid), 64'd1);
        chk({tag, "_req"}, 64'(bus.rd_req), 64'(e));
        chk({tag, "_excl"}, 64'({bus.ld_valid, bus.gemm_valid}), 64'd0);
        @(negedge clk);
    endtask

    task automatic exp_idle(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_valids"}, 64'({bus.rd_valid, bus.ld_valid, bus.gemm_valid}), 64'd0);
        chk({tag, "_ready"}, 64'(bus.instr_ready), 64'd1);
    endtask

    task automatic run_load(input string tag, input logic [3:0] m, input logic [31:0] base,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] a2, input logic [31:0] a3);
        logic [31:0] ea [4];
        ea[0] = a0; ea[1] = a1; ea[2] = a2; ea[3] = a3;
        push(2'b01, {2'b00, m}, base);
        for (int r = 0; r < 4; r++) begin
            chk({tag, "_ldv"}, 64'(bus.ld_valid), 64'd1);
            chk({tag, "_addr"}, 64'(bus.ld_addr), 64'(ea[r]));
            chk({tag, "_mat"}, 64'(bus.ld_mat_s), 64'(m));
            chk({tag, "_row"}, 64'(bus.ld_row_s), 64'(r));
            chk({tag, "_excl"}, 64'({bus.rd_valid, bus.gemm_valid}), 64'd0);
            @(negedge clk);
        end
        exp_idle({tag, "_end"});
    endtask

    initial begin
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.rd_ready = 1'b1;
        bus.ld_ready = 1'b1;
        bus.gemm_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_valids", 64'({bus.rd_valid, bus.ld_valid, bus.gemm_valid}), 64'd0);
        chk("rst_illegal", 64'(bus.illegal_op), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        exp_idle("post_rst");

        // LOAD mat 5 at 0x1000, four back-to-back rows
        run_load("load", 4'd5, 32'h1000, 32'h1000, 32'h1008, 32'h1010, 32'h1018);

        // STORE mat 2 at 0x40 with row 1 stalled for three cycles
        push(2'b10, 6'd2, 32'h40);
        exp_rd("st_r0", mk_rd(32'h40, 2'b00, 4'd2, 2'd0));
        bus.rd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("st_hold_v", 64'(bus.rd_valid), 64'd1);
            chk("st_hold_req", 64'(bus.rd_req), 64'(mk_rd(32'h48, 2'b00, 4'd2, 2'd1)));
            @(negedge clk);
        end
        bus.rd_ready = 1'b1;
        exp_rd("st_r1", mk_rd(32'h48, 2'b00, 4'd2, 2'd1));
        exp_rd("st_r2", mk_rd(32'h50, 2'b00, 4'd2, 2'd2));
        exp_rd("st_r3", mk_rd(32'h58, 2'b00, 4'd2, 2'd3));
        exp_idle("st_end");

        // GEMM new_weight=1 sel=0x1234: weight mat 2, input mat 1, psum mat 3, rd 4
        push(2'b11, 6'b10_0000, 32'h1234);
        for (int r = 0; r < 4; r++) exp_rd("g1_wgt", mk_rd(32'h0, 2'b01, 4'd2, 2'(r)));
        for (int r = 0; r < 4; r++) exp_rd("g1_in",  mk_rd(32'h0, 2'b10, 4'd1, 2'(r)));
        for (int r = 0; r < 4; r++) exp_rd("g1_ps",  mk_rd(32'h0, 2'b11, 4'd3, 2'(r)));
        chk("g1_disp_v", 64'(bus.gemm_valid), 64'd1);
        chk("g1_disp_rd", 64'(bus.gemm_rd), 64'd4);
        chk("g1_disp_excl", 64'({bus.rd_valid, bus.ld_valid}), 64'd0);
        @(negedge clk);
        exp_idle("g1_end");

        // GEMM new_weight=0 sel=0x5678 with the dispatch held off for two cycles
        bus.gemm_ready = 1'b0;
        push(2'b11, 6'b00_0000, 32'h5678);
        for (int r = 0; r < 4; r++) exp_rd("g2_in", mk_rd(32'h0, 2'b10, 4'd5, 2'(r)));
        for (int r = 0; r < 4; r++) exp_rd("g2_ps", mk_rd(32'h0, 2'b11, 4'd7, 2'(r)));
        for (int k = 0; k < 2; k++) begin
            chk("g2_hold_v", 64'(bus.gemm_valid), 64'd1);
            chk("g2_hold_rd", 64'(bus.gemm_rd), 64'd8);
            @(negedge clk);
        end
        bus.gemm_ready = 1'b1;
        chk("g2_disp_v", 64'(bus.gemm_valid), 64'd1);
        @(negedge clk);
        exp_idle("g2_end");

        // LOAD whose row addresses wrap past 2**32
        run_load("wrap", 4'd0, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h0, 32'h8, 32'h10);

        // Reset pulse while in G_IN discards the instruction
        push(2'b11, 6'b00_0000, 32'h1234);
        exp_rd("rst_gin", mk_rd(32'h0, 2'b10, 4'd1, 2'd0));
        rst = 1'b1;
        #1;
        chk("rst_mid_valids", 64'({bus.rd_valid, bus.ld_valid, bus.gemm_valid}), 64'd0);
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_idle("rst_mid_after");

        // Illegal opcode: one-cycle flag, nothing issued
        push(2'b00, 6'd3, 32'hABCD);
        chk("ill_pulse", 64'(bus.illegal_op), 64'd1);
        exp_idle("ill_idle");
        @(negedge clk);
        chk("ill_clear", 64'(bus.illegal_op), 64'd0);
        exp_idle("ill_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
